int2flt_seq: RTL

//  Sequential 16-bit two's-complement integer -> IEEE-754 half-precision converter with round-to-nearest-even.
//  It is the upstream stage of the float->integer program: it produces the half float that flt2int consumes.
//  It reads the operand from byte-wide data memory and writes the result back, with the same Start/Done contract as Top.

---
 rtl/int2flt_pkg.sv | 21 ++
 rtl/int2flt_round.sv | 32 +++
 rtl/int2flt_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/int2flt_pkg.sv
// rtl/int2flt_pkg.sv - shared states and field widths for the int->half converter
package int2flt_pkg;

  localparam int EXP_BIAS = 15;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int INT_W    = 16;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    ABS,
    NORM,
    ROUND,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

endpackage

// File: rtl/int2flt_round.sv
// rtl/int2flt_round.sv - round-to-nearest-even packing of a normalized magnitude into a half
module int2flt_round
  import int2flt_pkg::*;
(
  input  logic             sign,
  input  logic [3:0]       k,
  input  logic [INT_W-1:0] mag,
  output logic [15:0]      half
);

  logic [FRAC_W-1:0] frac;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [FRAC_W:0]   frac_sum;
  logic [EXP_W-1:0]  exp_base;
  logic [EXP_W-1:0]  exp_final;

  // mag[15] is the hidden one; the next ten bits are the stored fraction
  always_comb begin
    frac      = mag[14:5];
    guard     = mag[4];
    sticky    = |mag[3:0];
    round_up  = guard & (sticky | frac[0]);
    frac_sum  = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
    exp_base  = {1'b0, k} + EXP_W'(EXP_BIAS);
    // a carry out of the fraction means the value rounded up to the next power of two
    exp_final = frac_sum[FRAC_W] ? exp_base + 5'd1 : exp_base;
    half      = {sign, exp_final, frac_sum[FRAC_W-1:0]};
  end

endmodule

// File: rtl/int2flt_seq.sv
// rtl/int2flt_seq.sv - memory-sequenced 16-bit integer to half-precision converter
module int2flt_seq
  import int2flt_pkg::*;
#(
  parameter logic [7:0] IN_ADDR  = 8'd0,
  parameter logic [7:0] OUT_ADDR = 8'd2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  state_t state, next_state;

  logic             armed;
  logic [7:0]       lo_byte;
  logic [7:0]       hi_byte;
  logic             sign;
  logic [INT_W-1:0] mag;
  logic [3:0]       k;
  logic [15:0]      result;

  logic [INT_W-1:0] x_in;
  logic [INT_W-1:0] abs_val;
  logic             in_zero;
  logic [15:0]      half;
  logic             idle_like;

  // two's-complement magnitude; 16 bits suffice because -32768 wraps to 0x8000 exactly
  always_comb begin
    x_in      = {hi_byte, lo_byte};
    abs_val   = x_in[15] ? (16'd0 - x_in) : x_in;
    in_zero   = (x_in == 16'd0);
    idle_like = (state == IDLE) || (state == DONE);
  end

  int2flt_round u_round (
    .sign (sign),
    .k    (k),
    .mag  (mag),
    .half (half)
  );

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // sequencing: launch on the first low Start after arming, then walk the pipeline
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (armed && !Start) next_state = RD_LO;
      RD_LO:      next_state = RD_HI;
      RD_HI:      next_state = ABS;
      ABS:        next_state = in_zero ? WR_LO : NORM;
      NORM:       next_state = mag[15] ? ROUND : NORM;
      ROUND:      next_state = WR_LO;
      WR_LO:      next_state = WR_HI;
      WR_HI:      next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // datapath: operand capture, abs, normalize shifter and result latch
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      armed   <= 1'b0;
      lo_byte <= 8'd0;
      hi_byte <= 8'd0;
      sign    <= 1'b0;
      mag     <= '0;
      k       <= 4'd0;
      result  <= 16'd0;
    end else begin
      // Start high while waiting arms; a low Start then either launches or leaves it disarmed
      armed <= idle_like ? Start : 1'b0;
      case (state)
        RD_LO: lo_byte <= mem_rd_data;
        RD_HI: hi_byte <= mem_rd_data;
        ABS: begin
          sign   <= in_zero ? 1'b0 : x_in[15];
          mag    <= abs_val;
          k      <= 4'd15;
          result <= 16'd0;
        end
        NORM: begin
          if (!mag[15]) begin
            mag <= mag << 1;
            k   <= k - 4'd1;
          end
        end
        ROUND:   result <= half;
        default: ;
      endcase
    end
  end

  // registered memory interface and Done, decoded from the state being entered
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Done        <= 1'b0;
      mem_addr    <= IN_ADDR;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'd0;
    end else begin
      if (idle_like && Start)
        Done <= 1'b0;
      else if (state == WR_HI && next_state == DONE)
        Done <= 1'b1;

      mem_wr_en <= (next_state == WR_LO) || (next_state == WR_HI);

      case (next_state)
        RD_HI:   mem_addr <= IN_ADDR + 8'd1;
        WR_LO:   mem_addr <= OUT_ADDR;
        WR_HI:   mem_addr <= OUT_ADDR + 8'd1;
        default: mem_addr <= IN_ADDR;
      endcase

      case (next_state)
        // the zero shortcut comes straight from ABS, where the result is all zeros
        WR_LO:   mem_wr_data <= (state == ROUND) ? half[7:0] : 8'd0;
        WR_HI:   mem_wr_data <= result[15:8];
        default: mem_wr_data <= 8'd0;
      endcase
    end
  end

endmodule
